// File: rtl/timer_irq_pkg.sv
// Shared types and default sizing for the timer interrupt controller.
package timer_irq_pkg;

  // Controller states: request presented, serviced, cleared, then a settle cycle.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    ACTIVE  = 3'd2,
    CLEAR   = 3'd3,
    HOLDOFF = 3'd4
  } irq_state_e;

  localparam int DEF_NUM_SRC = 4;
  localparam int DEF_SPUR_W  = 8;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins, so source 0 is most urgent.
module irq_prio_enc
  import timer_irq_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] pending_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    index_o
);

  // Scan from the top down so the last hit (the lowest index) is what remains.
  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending_i[i]) begin
        valid_o = 1'b1;
        index_o = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Consumer-side timer interrupt controller: masks and prioritises channel
// interrupts, runs the req/ack/eoi handshake with the CPU, and returns a
// one-cycle clear pulse to the serviced channel.
module timer_irq_ctrl
  import timer_irq_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int ID_W    = $clog2(NUM_SRC),
  parameter int SPUR_W  = DEF_SPUR_W
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic [NUM_SRC-1:0] src_mask,
  input  logic               cpu_ack,
  input  logic               cpu_eoi,
  output logic               cpu_irq,
  output logic [ID_W-1:0]    cpu_irq_id,
  output logic               irq_active,
  output logic [NUM_SRC-1:0] src_clr,
  output logic [SPUR_W-1:0]  spur_cnt
);

  irq_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] src_irq_q;
  logic [NUM_SRC-1:0] pending;
  logic               enc_valid;
  logic [ID_W-1:0]    enc_idx;
  logic               cpu_irq_q, cpu_irq_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               active_q, active_d;
  logic [NUM_SRC-1:0] clr_q, clr_d;
  logic [SPUR_W-1:0]  spur_q, spur_d;

  // The mask is applied unregistered, so a mask change acts one edge sooner than a source change.
  assign pending = src_irq_q & src_mask;

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .pending_i (pending),
    .valid_o   (enc_valid),
    .index_o   (enc_idx)
  );

  // Next-state and next-output decisions; clear pulse defaults low so it lasts one cycle.
  always_comb begin
    state_d   = state_q;
    cpu_irq_d = cpu_irq_q;
    id_d      = id_q;
    active_d  = active_q;
    clr_d     = '0;
    spur_d    = spur_q;
    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          id_d      = enc_idx;
          cpu_irq_d = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (cpu_ack) begin
          cpu_irq_d = 1'b0;
          active_d  = 1'b1;
          state_d   = ACTIVE;
        end else if (!pending[id_q]) begin
          cpu_irq_d = 1'b0;
          if (spur_q != {SPUR_W{1'b1}}) begin
            spur_d = spur_q + SPUR_W'(1);
          end
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (cpu_eoi) begin
          clr_d   = NUM_SRC'(1) << id_q;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d = HOLDOFF;
      end
      HOLDOFF: begin
        active_d = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, input sampling and all outputs are registered; reset drops everything at once.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      src_irq_q <= '0;
      cpu_irq_q <= 1'b0;
      id_q      <= '0;
      active_q  <= 1'b0;
      clr_q     <= '0;
      spur_q    <= '0;
    end else begin
      state_q   <= state_d;
      src_irq_q <= src_irq;
      cpu_irq_q <= cpu_irq_d;
      id_q      <= id_d;
      active_q  <= active_d;
      clr_q     <= clr_d;
      spur_q    <= spur_d;
    end
  end

  assign cpu_irq    = cpu_irq_q;
  assign cpu_irq_id = id_q;
  assign irq_active = active_q;
  assign src_clr    = clr_q;
  assign spur_cnt   = spur_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl with a queue of expected output snapshots.
module tb_timer_irq_ctrl;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [3:0] src_irq;
  logic [3:0] src_mask;
  logic       cpu_ack;
  logic       cpu_eoi;
  logic       cpu_irq;
  logic [1:0] cpu_irq_id;
  logic       irq_active;
  logic [3:0] src_clr;
  logic [7:0] spur_cnt;

  typedef struct {
    string      tag;
    logic       irq;
    logic [1:0] id;
    logic       act;
    logic [3:0] clr;
    logic [7:0] spur;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   fails  = 0;

  timer_irq_ctrl dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .src_irq    (src_irq),
    .src_mask   (src_mask),
    .cpu_ack    (cpu_ack),
    .cpu_eoi    (cpu_eoi),
    .cpu_irq    (cpu_irq),
    .cpu_irq_id (cpu_irq_id),
    .irq_active (irq_active),
    .src_clr    (src_clr),
    .spur_cnt   (spur_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] irq, input logic [3:0] mask,
                               input logic ack, input logic eoi);
    src_irq  = irq;
    src_mask = mask;
    cpu_ack  = ack;
    cpu_eoi  = eoi;
  endtask

  task automatic pushExpect(input string tag, input logic irq, input logic [1:0] id,
                            input logic act, input logic [3:0] clr, input logic [7:0] spur);
    exp_t e;
    e.tag  = tag;
    e.irq  = irq;
    e.id   = id;
    e.act  = act;
    e.clr  = clr;
    e.spur = spur;
    sbq.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (sbq.size() != 0) else begin
      fails++;
      $error("[TB] FAIL scoreboard_empty observed=0 entries expected>=1");
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      checks++;
      assert (cpu_irq === e.irq) else begin
        fails++;
        $error("[TB] FAIL %s.cpu_irq observed=%0b expected=%0b", e.tag, cpu_irq, e.irq);
      end
      checks++;
      assert (cpu_irq_id === e.id) else begin
        fails++;
        $error("[TB] FAIL %s.cpu_irq_id observed=%0d expected=%0d", e.tag, cpu_irq_id, e.id);
      end
      checks++;
      assert (irq_active === e.act) else begin
        fails++;
        $error("[TB] FAIL %s.irq_active observed=%0b expected=%0b", e.tag, irq_active, e.act);
      end
      checks++;
      assert (src_clr === e.clr) else begin
        fails++;
        $error("[TB] FAIL %s.src_clr observed=%b expected=%b", e.tag, src_clr, e.clr);
      end
      checks++;
      assert (spur_cnt === e.spur) else begin
        fails++;
        $error("[TB] FAIL %s.spur_cnt observed=%0d expected=%0d", e.tag, spur_cnt, e.spur);
      end
    end
  endtask

  // Push the expected outputs, advance one edge, then compare what the DUT produced.
  task automatic stepCheck(input string tag, input logic irq, input logic [1:0] id,
                           input logic act, input logic [3:0] clr, input logic [7:0] spur);
    pushExpect(tag, irq, id, act, clr, spur);
    tick();
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sys_rst_n = 1'b0;
    applyStimulus(4'b0000, 4'hF, 1'b0, 1'b0);
    tick();
    pushExpect("reset", 1'b0, 2'd0, 1'b0, 4'b0000, 8'd0);
    checkOutput();
    tick();
    sys_rst_n = 1'b1;

    // Single source: request on 2nd edge, ack, eoi, clear, holdoff.
    applyStimulus(4'b0100, 4'hF, 1'b0, 1'b0);
    stepCheck("t1_edge1", 1'b0, 2'd0, 1'b0, 4'b0000, 8'd0);
    stepCheck("t1_req", 1'b1, 2'd2, 1'b0, 4'b0000, 8'd0);
    applyStimulus(4'b0100, 4'hF, 1'b1, 1'b0);
    stepCheck("t1_ack", 1'b0, 2'd2, 1'b1, 4'b0000, 8'd0);
    applyStimulus(4'b0100, 4'hF, 1'b0, 1'b1);
    stepCheck("t1_clr", 1'b0, 2'd2, 1'b1, 4'b0100, 8'd0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 1'b0);
    stepCheck("t1_holdoff", 1'b0, 2'd2, 1'b1, 4'b0000, 8'd0);
    stepCheck("t1_idle", 1'b0, 2'd2, 1'b0, 4'b0000, 8'd0);
    stepCheck("t1_quiet", 1'b0, 2'd2, 1'b0, 4'b0000, 8'd0);

    // Two sources: id1 first, no preemption by bit0, then id3 four edges after eoi.
    applyStimulus(4'b1010, 4'hF, 1'b0, 1'b0);
    tick();
    stepCheck("t2_req1", 1'b1, 2'd1, 1'b0, 4'b0000, 8'd0);
    applyStimulus(4'b1011, 4'hF, 1'b0, 1'b0);
    stepCheck("t2_nopreempt_a", 1'b1, 2'd1, 1'b0, 4'b0000, 8'd0);
    stepCheck("t2_nopreempt_b", 1'b1, 2'd1, 1'b0, 4'b0000, 8'd0);
    applyStimulus(4'b1011, 4'hF, 1'b1, 1'b0);
    stepCheck("t2_ack1", 1'b0, 2'd1, 1'b1, 4'b0000, 8'd0);
    applyStimulus(4'b1011, 4'hF, 1'b0, 1'b1);
    stepCheck("t2_clr1", 1'b0, 2'd1, 1'b1, 4'b0010, 8'd0);
    applyStimulus(4'b1000, 4'hF, 1'b0, 1'b0);
    stepCheck("t2_holdoff", 1'b0, 2'd1, 1'b1, 4'b0000, 8'd0);
    stepCheck("t2_idle", 1'b0, 2'd1, 1'b0, 4'b0000, 8'd0);
    stepCheck("t2_req3", 1'b1, 2'd3, 1'b0, 4'b0000, 8'd0);
    applyStimulus(4'b1000, 4'hF, 1'b1, 1'b0);
    stepCheck("t2_ack3", 1'b0, 2'd3, 1'b1, 4'b0000, 8'd0);
    applyStimulus(4'b1000, 4'hF, 1'b0, 1'b1);
    stepCheck("t2_clr3", 1'b0, 2'd3, 1'b1, 4'b1000, 8'd0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 1'b0);
    tick();
    stepCheck("t2_done", 1'b0, 2'd3, 1'b0, 4'b0000, 8'd0);

    // Ack in the same cycle the source drops: ack wins, no spurious count.
    applyStimulus(4'b0010, 4'hF, 1'b0, 1'b0);
    tick();
    stepCheck("t5_req", 1'b1, 2'd1, 1'b0, 4'b0000, 8'd0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 1'b0);
    stepCheck("t5_drop", 1'b1, 2'd1, 1'b0, 4'b0000, 8'd0);
    applyStimulus(4'b0000, 4'hF, 1'b1, 1'b0);
    stepCheck("t5_ackwins", 1'b0, 2'd1, 1'b1, 4'b0000, 8'd0);
    stepCheck("t5_strayack", 1'b0, 2'd1, 1'b1, 4'b0000, 8'd0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 1'b1);
    stepCheck("t5_clr", 1'b0, 2'd1, 1'b1, 4'b0010, 8'd0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 1'b0);
    tick();
    stepCheck("t5_idle", 1'b0, 2'd1, 1'b0, 4'b0000, 8'd0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 1'b1);
    stepCheck("t5_strayeoi_idle", 1'b0, 2'd1, 1'b0, 4'b0000, 8'd0);

    // Stray eoi in REQ, then ack+eoi together: ack taken, eoi not remembered.
    applyStimulus(4'b0100, 4'hF, 1'b0, 1'b0);
    tick();
    stepCheck("t5b_req", 1'b1, 2'd2, 1'b0, 4'b0000, 8'd0);
    applyStimulus(4'b0100, 4'hF, 1'b0, 1'b1);
    stepCheck("t5b_strayeoi", 1'b1, 2'd2, 1'b0, 4'b0000, 8'd0);
    applyStimulus(4'b0100, 4'hF, 1'b1, 1'b1);
    stepCheck("t5b_ackeoi", 1'b0, 2'd2, 1'b1, 4'b0000, 8'd0);
    applyStimulus(4'b0100, 4'hF, 1'b0, 1'b0);
    stepCheck("t5b_noclr", 1'b0, 2'd2, 1'b1, 4'b0000, 8'd0);
    applyStimulus(4'b0100, 4'hF, 1'b0, 1'b1);
    stepCheck("t5b_clr", 1'b0, 2'd2, 1'b1, 4'b0100, 8'd0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 1'b0);
    tick();
    stepCheck("t5b_idle", 1'b0, 2'd2, 1'b0, 4'b0000, 8'd0);

    // Spurious withdrawals: count each, saturate at 255 after 300.
    applyStimulus(4'b0100, 4'hF, 1'b0, 1'b0);
    tick();
    stepCheck("t3_req", 1'b1, 2'd2, 1'b0, 4'b0000, 8'd0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 1'b0);
    stepCheck("t3_hold", 1'b1, 2'd2, 1'b0, 4'b0000, 8'd0);
    stepCheck("t3_spur1", 1'b0, 2'd2, 1'b0, 4'b0000, 8'd1);
    for (int n = 2; n <= 300; n++) begin
      applyStimulus(4'b0100, 4'hF, 1'b0, 1'b0);
      tick();
      tick();
      applyStimulus(4'b0000, 4'hF, 1'b0, 1'b0);
      tick();
      if (n == 254 || n == 255 || n == 300) begin
        stepCheck($sformatf("t3_spur%0d", n), 1'b0, 2'd2, 1'b0, 4'b0000,
                  (n >= 255) ? 8'd255 : 8'(n));
      end else begin
        tick();
      end
    end

    // Masked source stays silent; unmasking requests one edge later.
    applyStimulus(4'b0001, 4'b1110, 1'b0, 1'b0);
    tick();
    tick();
    stepCheck("t4_masked", 1'b0, 2'd2, 1'b0, 4'b0000, 8'd255);
    applyStimulus(4'b0001, 4'hF, 1'b0, 1'b0);
    stepCheck("t4_unmask", 1'b1, 2'd0, 1'b0, 4'b0000, 8'd255);
    applyStimulus(4'b0001, 4'hF, 1'b1, 1'b0);
    stepCheck("t4_ack", 1'b0, 2'd0, 1'b1, 4'b0000, 8'd255);

    // Reset while ACTIVE: outputs drop asynchronously and eoi issues no clear.
    #2;
    sys_rst_n = 1'b0;
    #1;
    pushExpect("t6_asyncrst", 1'b0, 2'd0, 1'b0, 4'b0000, 8'd0);
    checkOutput();
    applyStimulus(4'b0001, 4'hF, 1'b0, 1'b1);
    stepCheck("t6_noclr", 1'b0, 2'd0, 1'b0, 4'b0000, 8'd0);
    applyStimulus(4'b0001, 4'hF, 1'b0, 1'b0);
    sys_rst_n = 1'b1;
    stepCheck("t6_edge1", 1'b0, 2'd0, 1'b0, 4'b0000, 8'd0);
    stepCheck("t6_fresh", 1'b1, 2'd0, 1'b0, 4'b0000, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
